fdc_seek_ctrl: RTL and testbench

// Host/FDC-side head-positioning controller: the initiator of the floppy bus

---
 rtl/fdc_seek_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fdc_seek_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_seek_ctrl.sv
// Floppy head-positioning controller: runs SEEK/RECAL commands by issuing
// timed active-low step pulses on the drive cable and tracking head position.
module fdc_seek_ctrl #(
   parameter int DRIVE_NUM      = 1,
   parameter int MAX_TRACK      = 79,
   parameter int RECAL_MAX      = 84,
   parameter int DIR_SETUP_CYC  = 50,
   parameter int STEP_PULSE_CYC = 150,
   parameter int STEP_RATE_CYC  = 300000,
   parameter int SETTLE_CYC     = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_op,
   input  logic [6:0] cmd_track,
   input  logic       motor_req,
   input  logic       sel_req,
   output logic       done,
   output logic       err,
   output logic [6:0] cur_track,
   output logic       track_valid,
   output logic [3:0] drive_sel_n,
   output logic       motor_on_n,
   output logic       dir_sel_n,
   output logic       step_n,
   input  logic       track_0_n
);

   localparam int CNT_MAX_A = (SETTLE_CYC > STEP_RATE_CYC) ? SETTLE_CYC : STEP_RATE_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > DIR_SETUP_CYC) ? CNT_MAX_A : DIR_SETUP_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int PUL_W     = $clog2(RECAL_MAX + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(DIR_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(STEP_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(STEP_RATE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [PUL_W-1:0] PUL_LIMIT   = PUL_W'(RECAL_MAX);
   localparam logic [6:0]       TRK_MAX     = 7'(MAX_TRACK);
   localparam logic [3:0]       SEL_BIT     = 4'(1 << DRIVE_NUM);

   typedef enum logic [2:0] {
      IDLE, CHECK, DIR_SETUP, STEP_LO, STEP_HI, SETTLE, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [PUL_W-1:0] pulses, pulses_nxt;
   logic             op, op_nxt;
   logic [6:0]       target, target_nxt;
   logic [6:0]       cur_nxt;
   logic             tv_nxt;
   logic             dir_nxt;
   logic             step_nxt;
   logic             done_nxt;
   logic             err_nxt;
   logic             enter_step;
   logic             t0_meta, t0_sync;
   logic             t0;

   assign t0        = ~t0_sync;
   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      pulses_nxt = pulses;
      op_nxt     = op;
      target_nxt = target;
      cur_nxt    = cur_track;
      tv_nxt     = track_valid;
      dir_nxt    = dir_sel_n;
      step_nxt   = step_n;
      err_nxt    = err;
      enter_step = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               op_nxt     = cmd_op;
               target_nxt = cmd_track;
               err_nxt    = 1'b0;
               state_nxt  = CHECK;
            end
         end
         CHECK: begin
            cnt_nxt    = '0;
            pulses_nxt = '0;
            if (!op) begin
               if (!track_valid || target > TRK_MAX) begin
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end else if (target == cur_track) begin
                  err_nxt   = 1'b0;
                  state_nxt = DONE;
               end else begin
                  dir_nxt   = (target > cur_track) ? 1'b0 : 1'b1;
                  state_nxt = DIR_SETUP;
               end
            end else if (t0) begin
               cur_nxt   = '0;
               tv_nxt    = 1'b1;
               err_nxt   = 1'b0;
               state_nxt = DONE;
            end else begin
               dir_nxt   = 1'b1;
               state_nxt = DIR_SETUP;
            end
         end
         DIR_SETUP: begin
            if (cnt == SETUP_LAST) enter_step = 1'b1;
            else                   cnt_nxt = cnt + 1'b1;
         end
         STEP_LO: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == PULSE_LAST) begin
               step_nxt  = 1'b1;
               state_nxt = STEP_HI;
            end
         end
         STEP_HI: begin
            if (cnt != RATE_LAST) begin
               cnt_nxt = cnt + 1'b1;
            end else if (!op) begin
               // Outward seek hitting track 00 early means our position was wrong
               if (dir_sel_n && t0 && cur_track != 7'd0) begin
                  cur_nxt   = '0;
                  tv_nxt    = 1'b0;
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end else if (cur_track == target) begin
                  cnt_nxt   = '0;
                  state_nxt = SETTLE;
               end else begin
                  enter_step = 1'b1;
               end
            end else begin
               if (t0) begin
                  cur_nxt   = '0;
                  tv_nxt    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = SETTLE;
               end else if (pulses == PUL_LIMIT) begin
                  tv_nxt    = 1'b0;
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  enter_step = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               err_nxt   = 1'b0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Head position moves at the falling edge of each step pulse
      if (enter_step) begin
         state_nxt  = STEP_LO;
         step_nxt   = 1'b0;
         cnt_nxt    = '0;
         pulses_nxt = pulses + 1'b1;
         if (!dir_sel_n)              cur_nxt = cur_track + 7'd1;
         else if (cur_track != 7'd0)  cur_nxt = cur_track - 7'd1;
      end

      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         pulses      <= '0;
         op          <= 1'b0;
         target      <= '0;
         cur_track   <= '0;
         track_valid <= 1'b0;
         dir_sel_n   <= 1'b1;
         step_n      <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         drive_sel_n <= 4'hF;
         motor_on_n  <= 1'b1;
         t0_meta     <= 1'b1;
         t0_sync     <= 1'b1;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         pulses      <= pulses_nxt;
         op          <= op_nxt;
         target      <= target_nxt;
         cur_track   <= cur_nxt;
         track_valid <= tv_nxt;
         dir_sel_n   <= dir_nxt;
         step_n      <= step_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
         drive_sel_n <= (sel_req || state != IDLE) ? ~SEL_BIT : 4'hF;
         motor_on_n  <= ~motor_req;
         t0_meta     <= track_0_n;
         t0_sync     <= t0_meta;
      end
   end

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Scoreboard bench for fdc_seek_ctrl with short timing parameters; a monitor
// checks step pulse shape and pops expected results when done fires.
module tb_fdc_seek_ctrl;

   localparam int PULSE = 2;
   localparam int RATE  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_op = 1'b0;
   logic [6:0] cmd_track = '0;
   logic       motor_req = 1'b0;
   logic       sel_req = 1'b0;
   logic       done, err;
   logic [6:0] cur_track;
   logic       track_valid;
   logic [3:0] drive_sel_n;
   logic       motor_on_n, dir_sel_n, step_n;
   logic       track_0_n = 1'b1;

   fdc_seek_ctrl #(
      .DRIVE_NUM(1), .MAX_TRACK(79), .RECAL_MAX(10), .DIR_SETUP_CYC(2),
      .STEP_PULSE_CYC(PULSE), .STEP_RATE_CYC(RATE), .SETTLE_CYC(5)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_track(cmd_track), .motor_req(motor_req),
      .sel_req(sel_req), .done(done), .err(err), .cur_track(cur_track),
      .track_valid(track_valid), .drive_sel_n(drive_sel_n),
      .motor_on_n(motor_on_n), .dir_sel_n(dir_sel_n), .step_n(step_n),
      .track_0_n(track_0_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       err;
      logic [6:0] trk;
      logic       tv;
      int         pulses;
   } exp_t;

   exp_t sb[$];
   exp_t e_pop;
   int   errors = 0, checks = 0;
   int   cyc = 0;
   int   npulse = 0, first_fall = 0, last_fall = 0, last_rise = 0;
   int   dir_chg_cyc = 0, done_cyc = 0, accept_cyc = 0;
   bit   got_done = 0;
   logic exp_dir = 1'b1;
   logic prev_step = 1'b1, prev_dir = 1'b1;
   logic [6:0] trk_at_fall [0:15];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic e, input logic [6:0] t, input logic v, input int p);
      exp_t r;
      r.err = e; r.trk = t; r.tv = v; r.pulses = p;
      return r;
   endfunction

   // Monitor: pulse timing, direction, and scoreboard pop on done
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prev_dir !== dir_sel_n) dir_chg_cyc = cyc;
            if (prev_step === 1'b1 && step_n === 1'b0) begin
               npulse++;
               if (npulse == 1) first_fall = cyc;
               if (npulse > 1) begin
                  checks++;
                  if (cyc - last_fall != RATE) begin
                     errors++;
                     $display("FAIL step_period: got %0d want %0d", cyc - last_fall, RATE);
                  end
               end
               checks++;
               if (dir_sel_n !== exp_dir) begin
                  errors++;
                  $display("FAIL step_dir: got %b want %b", dir_sel_n, exp_dir);
               end
               if (npulse < 16) trk_at_fall[npulse] = cur_track;
               last_fall = cyc;
            end
            if (prev_step === 1'b0 && step_n === 1'b1) begin
               last_rise = cyc;
               checks++;
               if (cyc - last_fall != PULSE) begin
                  errors++;
                  $display("FAIL step_width: got %0d want %0d", cyc - last_fall, PULSE);
               end
            end
            if (done === 1'b1) begin
               got_done = 1;
               done_cyc = cyc;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: got done with empty scoreboard");
               end else begin
                  e_pop = sb.pop_front();
                  if (err !== e_pop.err || cur_track !== e_pop.trk ||
                      track_valid !== e_pop.tv || npulse != e_pop.pulses ||
                      drive_sel_n !== 4'hD) begin
                     errors++;
                     $display("FAIL done_result: got err=%b trk=%0d tv=%b pulses=%0d sel=%h want err=%b trk=%0d tv=%b pulses=%0d sel=d",
                              err, cur_track, track_valid, npulse, drive_sel_n,
                              e_pop.err, e_pop.trk, e_pop.tv, e_pop.pulses);
                  end
               end
            end
         end
         prev_step = step_n;
         prev_dir  = dir_sel_n;
      end
   end

   task automatic send(input logic op, input logic [6:0] trk, input logic ed, input exp_t e);
      @(negedge clk);
      npulse   = 0;
      got_done = 0;
      exp_dir  = ed;
      sb.push_back(e);
      cmd_valid = 1'b1; cmd_op = op; cmd_track = trk;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget && !got_done; i++) @(posedge clk);
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
         if (sb.size() > 0) sb.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      checks += 9;
      if (cmd_ready !== 1'b1)      begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      if (done !== 1'b0)           begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      if (err !== 1'b0)            begin errors++; $display("FAIL rst_err: got %b want 0", err); end
      if (cur_track !== 7'd0)      begin errors++; $display("FAIL rst_track: got %0d want 0", cur_track); end
      if (track_valid !== 1'b0)    begin errors++; $display("FAIL rst_tv: got %b want 0", track_valid); end
      if (drive_sel_n !== 4'hF)    begin errors++; $display("FAIL rst_sel: got %h want f", drive_sel_n); end
      if (motor_on_n !== 1'b1)     begin errors++; $display("FAIL rst_motor: got %b want 1", motor_on_n); end
      if (dir_sel_n !== 1'b1)      begin errors++; $display("FAIL rst_dir: got %b want 1", dir_sel_n); end
      if (step_n !== 1'b1)         begin errors++; $display("FAIL rst_step: got %b want 1", step_n); end
   endtask

   task automatic test_select;
      @(negedge clk); motor_req = 1'b1; sel_req = 1'b1;
      @(negedge clk);
      checks += 2;
      if (motor_on_n !== 1'b0)  begin errors++; $display("FAIL motor_on: got %b want 0", motor_on_n); end
      if (drive_sel_n !== 4'hD) begin errors++; $display("FAIL sel_on: got %h want d", drive_sel_n); end
      motor_req = 1'b0; sel_req = 1'b0;
      @(negedge clk);
      checks += 2;
      if (motor_on_n !== 1'b1)  begin errors++; $display("FAIL motor_off: got %b want 1", motor_on_n); end
      if (drive_sel_n !== 4'hF) begin errors++; $display("FAIL sel_off: got %h want f", drive_sel_n); end
   endtask

   task automatic test_seek_unknown;
      send(1'b0, 7'd5, 1'b0, mk(1'b1, 7'd0, 1'b0, 0));
      wait_done(20, "seek_unknown");
   endtask

   task automatic test_recal_t0;
      send(1'b1, 7'd0, 1'b1, mk(1'b0, 7'd0, 1'b1, 3));
      for (int i = 0; i < 200 && npulse < 3; i++) @(posedge clk);
      #1 track_0_n = 1'b0;
      wait_done(200, "recal_t0");
      track_0_n = 1'b1;
   endtask

   task automatic test_seek_inward;
      send(1'b0, 7'd4, 1'b0, mk(1'b0, 7'd4, 1'b1, 4));
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", cmd_ready); end
      // A request while busy must be ignored
      cmd_valid = 1'b1; cmd_track = 7'd9;
      repeat (10) @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_done(300, "seek_in");
      checks += 4;
      if (first_fall - dir_chg_cyc < 2) begin errors++; $display("FAIL dir_setup: got %0d want >=2", first_fall - dir_chg_cyc); end
      if (trk_at_fall[1] !== 7'd1) begin errors++; $display("FAIL trk_pulse1: got %0d want 1", trk_at_fall[1]); end
      if (trk_at_fall[4] !== 7'd4) begin errors++; $display("FAIL trk_pulse4: got %0d want 4", trk_at_fall[4]); end
      if (done_cyc - last_rise < 5) begin errors++; $display("FAIL settle: got %0d want >=5", done_cyc - last_rise); end
   endtask

   task automatic test_seek_same;
      send(1'b0, 7'd4, 1'b0, mk(1'b0, 7'd4, 1'b1, 0));
      wait_done(10, "seek_same");
      checks++;
      if (done_cyc - accept_cyc > 3) begin errors++; $display("FAIL same_latency: got %0d want <=3", done_cyc - accept_cyc); end
   endtask

   task automatic test_seek_outward;
      send(1'b0, 7'd1, 1'b1, mk(1'b0, 7'd1, 1'b1, 3));
      wait_done(300, "seek_out");
   endtask

   task automatic test_recal_fail;
      send(1'b1, 7'd0, 1'b1, mk(1'b1, 7'd0, 1'b0, 10));
      wait_done(400, "recal_fail");
      checks++;
      if (trk_at_fall[10] !== 7'd0) begin errors++; $display("FAIL recal_sat: got %0d want 0", trk_at_fall[10]); end
   endtask

   task automatic test_reset_mid;
      track_0_n = 1'b0;
      repeat (3) @(posedge clk);
      send(1'b1, 7'd0, 1'b1, mk(1'b0, 7'd0, 1'b1, 0));
      wait_done(10, "recal_at_t0");
      track_0_n = 1'b1;
      repeat (3) @(posedge clk);
      send(1'b0, 7'd3, 1'b0, mk(1'b0, 7'd3, 1'b1, 3));
      for (int i = 0; i < 100 && npulse < 1; i++) @(posedge clk);
      #1;
      checks++;
      if (step_n !== 1'b0) begin errors++; $display("FAIL mid_pulse: got step_n=%b want 0", step_n); end
      rst = 1'b1;
      #1;
      sb.delete();
      checks += 8;
      if (step_n !== 1'b1)      begin errors++; $display("FAIL mid_rst_step: got %b want 1", step_n); end
      if (dir_sel_n !== 1'b1)   begin errors++; $display("FAIL mid_rst_dir: got %b want 1", dir_sel_n); end
      if (cur_track !== 7'd0)   begin errors++; $display("FAIL mid_rst_track: got %0d want 0", cur_track); end
      if (track_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tv: got %b want 0", track_valid); end
      if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); end
      if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got done=%b err=%b want 0 0", done, err); end
      if (drive_sel_n !== 4'hF) begin errors++; $display("FAIL mid_rst_sel: got %h want f", drive_sel_n); end
      if (motor_on_n !== 1'b1)  begin errors++; $display("FAIL mid_rst_motor: got %b want 1", motor_on_n); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checks += 2;
      if (got_done) begin errors++; $display("FAIL mid_rst_nodone: got done=1 want 0"); end
      if (step_n !== 1'b1 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst_idle: got step_n=%b ready=%b want 1 1", step_n, cmd_ready);
      end
   endtask

   initial begin
      test_reset;
      test_select;
      test_seek_unknown;
      test_recal_t0;
      test_seek_inward;
      test_seek_same;
      test_seek_outward;
      test_recal_fail;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
